// File: rtl/serial_to_parallel_demux.sv
// rtl/serial_to_parallel_demux.sv - serial bit stream to parallel word demux with valid/ready output slot
module serial_to_parallel_demux #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = 3,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [SEL_W-1:0] lane_sel,
    output logic             partial_drop
);

    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(WIDTH - 1);

    logic [SEL_W-1:0] lane_sel_q, lane_sel_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_valid_q, word_valid_d;
    logic             partial_drop_q, partial_drop_d;

    logic             at_last;
    logic             accept;
    logic             complete;
    logic [SEL_W-1:0] lane_idx;
    logic [SEL_W-1:0] bit_pos;

    always_comb begin
        at_last   = (lane_sel_q == LAST_LANE);
        bit_ready = ~at_last | frame_start | ~word_valid_q | word_ready;
        accept    = bit_valid & bit_ready;
        complete  = accept & ~frame_start & at_last;

        // frame_start forces the bit into the first lane of the mapping
        lane_idx = frame_start ? '0 : lane_sel_q;
        bit_pos  = MSB_FIRST ? (LAST_LANE - lane_idx) : lane_idx;

        asm_d = asm_q;
        if (accept) begin
            asm_d[bit_pos] = bit_in;
        end

        lane_sel_d = lane_sel_q;
        if (accept) begin
            if (frame_start) begin
                lane_sel_d = SEL_W'(1);
            end else if (at_last) begin
                lane_sel_d = '0;
            end else begin
                lane_sel_d = lane_sel_q + SEL_W'(1);
            end
        end

        // a completion on the same edge as a transfer keeps the slot full
        word_valid_d   = complete | (word_valid_q & ~word_ready);
        word_d         = complete ? asm_d : word_q;
        partial_drop_d = accept & frame_start & (lane_sel_q != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_sel_q     <= '0;
            asm_q          <= '0;
            word_q         <= '0;
            word_valid_q   <= 1'b0;
            partial_drop_q <= 1'b0;
        end else begin
            lane_sel_q     <= lane_sel_d;
            asm_q          <= asm_d;
            word_q         <= word_d;
            word_valid_q   <= word_valid_d;
            partial_drop_q <= partial_drop_d;
        end
    end

    assign word_out     = word_q;
    assign word_valid   = word_valid_q;
    assign lane_sel     = lane_sel_q;
    assign partial_drop = partial_drop_q;

endmodule

// File: doc/serial_to_parallel_demux.md
Name: serial_to_parallel_demux

Overview:
Receive end of the CAM validation serial test path. A counter-driven 8:1 mux serialises a validation word one bit per transfer; this block demultiplexes that bit stream back into parallel words. Each accepted bit is steered to the lane picked by an internal 3-bit lane counter. A completed word goes into a single-entry output register with a valid/ready handshake. A frame_start input resynchronises the lane counter and flags any discarded partial word.

Parameters:
WIDTH, 8, number of lanes/bits per word; power of two, minimum 2
SEL_W, 3, lane counter width, equals log2(WIDTH)
MSB_FIRST, 0, 0 = first bit of a word lands in lane 0; 1 = first bit lands in lane WIDTH-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is valid this cycle
frame_start  input  1  qualified by bit_valid; this bit is bit 0 of a new word
bit_ready  output  1  block accepts bit_in this cycle
word_out  output  WIDTH  assembled parallel word
word_valid  output  1  word_out holds a complete word
word_ready  input  1  consumer accepts word_out this cycle
lane_sel  output  SEL_W  index of the next bit within the word (0..WIDTH-1)
partial_drop  output  1  one-cycle pulse: a partial word was discarded by frame_start

Behaviour:
- Reset (asynchronous assert, synchronous release) clears lane_sel, the assembly register, word_out, word_valid and partial_drop to 0.
- Accept: bit_valid & bit_ready. Output transfer: word_valid & word_ready.
- Lane mapping:
  - Lane index L = lane_sel when MSB_FIRST=0.
  - L = WIDTH-1-lane_sel when MSB_FIRST=1.
  - An accepted bit is written to assembly bit L. Other assembly bits hold.
- Counter: on accept, lane_sel increments and wraps from WIDTH-1 to 0. With no accept, it holds.
- Completion:
  - An accept at lane_sel = WIDTH-1 without frame_start completes the word.
  - At that same edge, word_out loads the assembly contents with the current bit merged in, and word_valid goes to 1.
  - Latency: word_valid is high in the cycle after the last bit is accepted.
  - The assembly register does not need clearing; every bit is overwritten each word.
- bit_ready = (lane_sel != WIDTH-1) | frame_start | ~word_valid | word_ready.
  - This is combinational from word_ready, frame_start and the internal state. Consumers must not make word_ready depend on bit_ready.
  - A completing bit stalls only when the output slot is full and not draining.
- Output slot:
  - word_valid clears on a transfer unless a completion occurs at the same edge. In that case it stays 1 and word_out takes the new word (full throughput, no bubble).
  - word_out is stable while word_valid=1 and word_ready=0.
- frame_start (evaluated only on accept):
  - The bit is written to lane 0 of the mapping (assembly bit 0, or bit WIDTH-1 if MSB_FIRST=1), and lane_sel becomes 1.
  - If lane_sel != 0 before the accept, partial_drop pulses high for exactly the next cycle. Otherwise partial_drop stays 0.
  - frame_start never completes a word, even when lane_sel = WIDTH-1.
  - frame_start without bit_valid is ignored.
- partial_drop is registered and defaults to 0 every cycle.
- Reset mid-word: the partial word is discarded, any pending word_out is lost, and the next accepted bit goes to lane 0.

Test Plan:
- LSB-first, word_ready=1, stream 1,0,1,0,0,1,0,1 on consecutive cycles -> word_out=0xA5, word_valid=1 for exactly one cycle, one cycle after the 8th accept; lane_sel back to 0.
- MSB_FIRST=1, stream 0,0,0,1,0,0,1,0 -> word_out=0x12. The same stream with MSB_FIRST=0 -> 0x48.
- word_ready=0, 16 bits offered back-to-back:
  - first 15 are accepted; word_out=first word, stable;
  - bit_ready=0 at lane_sel=7;
  - raising word_ready for one cycle accepts the 16th bit and loads the second word the same edge, with word_valid staying 1.
- Continuous stream for 0x3C then 0xC3, word_ready=1 -> 16 accepts in 16 cycles, word_valid pulses at cycles 9 and 17, values 0x3C then 0xC3.
- 3 bits sent, then a bit with frame_start=1 followed by 7 bits forming 0x5A -> partial_drop pulses once, word_out=0x5A, no word emitted for the 3 dropped bits.
- reset asserted mid-word (lane_sel=5) and while word_valid=1 -> all outputs 0 immediately; next 8 bits yield the correct word.
